// File: rtl/i2c_target_str_rd.sv
// i2c_target_str_rd
//   I2C target that serves a 16-byte read-only ID string to an external initiator.
//   A write transaction sets the byte pointer ([addr+W][ptr]); a read transaction
//   returns string bytes from the pointer onwards with auto-increment (wraps 15 -> 0).
//
//   Optional feature (compile-time macro I2C_STR_SNAPSHOT_EN):
//     defined   - str_i is captured into a snapshot register at the address ACK of every
//                 read, and all bytes of that read come from the snapshot.
//     undefined - each byte is taken live from str_i when it is loaded.
//
// Ports
//   clk       system clock (>= 20x SCL rate)
//   rst_n     asynchronous active-low reset
//   i2c_addr  7-bit target address, compared at each address byte
//   str_i     string, byte k = str_i[k*8 +: 8], byte 0 sent first
//   scl_i     SCL pin level (asynchronous)
//   sda_i     SDA pin level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   busy      1 while addressed (address ACK until STOP/START)
//   ptr       current byte pointer
module i2c_target_str_rd #(
    parameter int FILT_LEN = 3,
    parameter int SDA_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:1]   i2c_addr,
    input  logic [0:127] str_i,
    input  logic         scl_i,
    input  logic         sda_i,
    output logic         sda_oe,
    output logic         busy,
    output logic [3:0]   ptr
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DISC,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam int            FW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] FILT_MAX  = FW'(FILT_LEN - 1);
    localparam int            HW        = $clog2(SDA_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(SDA_HOLD);

    function automatic logic [7:0] str_byte(input logic [0:127] s, input logic [3:0] k);
        return s[{k, 3'b000} +: 8];
    endfunction

    // Synchronizer, glitch filter and edge history
    logic [1:0]    scl_s_q, sda_s_q;
    logic          scl_f_q, sda_f_q;
    logic          scl_p_q, sda_p_q;
    logic [FW-1:0] scl_cnt_q, sda_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s_q   <= '0;
            sda_s_q   <= '0;
            scl_f_q   <= 1'b0;
            sda_f_q   <= 1'b0;
            scl_p_q   <= 1'b0;
            sda_p_q   <= 1'b0;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_i};
            sda_s_q <= {sda_s_q[0], sda_i};
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            // A filtered level only follows the synchronized one after FILT_LEN
            // consecutive differing samples; any agreeing sample restarts the count.
            if (scl_s_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FILT_MAX) begin
                scl_f_q   <= scl_s_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FILT_MAX) begin
                sda_f_q   <= sda_s_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f_q & ~scl_p_q;
    assign scl_fall  = ~scl_f_q & scl_p_q;
    assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

    // Protocol FSM
    state_t     state_q;
    logic [3:0] bitcnt_q;
    logic [7:0] sh_q;
    logic [7:0] tx_q;
    logic       rw_q;
    logic       ack_q;
    logic       drv_q;
    logic [HW-1:0] hold_q;
    logic       sda_oe_q;
    logic       busy_q;
    logic [3:0] ptr_q;

    logic         addr_match;
    logic [0:127] src_str;
    logic [3:0]   ptr_inc_d;
    logic [7:0]   byte_first_d;
    logic [7:0]   byte_next_d;

    // General call (0x00) is never acknowledged, even if i2c_addr is 0.
    assign addr_match   = (sh_q[7:1] == i2c_addr) && (sh_q[7:1] != 7'd0);
    assign ptr_inc_d    = ptr_q + 4'd1;
    assign byte_first_d = str_byte(src_str, ptr_q);
    assign byte_next_d  = str_byte(src_str, ptr_inc_d);

`ifdef I2C_STR_SNAPSHOT_EN
    logic [0:127] snap_q;
    logic         snap_cap;

    // Capture at the fall that enters the address ACK of a read, i.e. before the
    // first data byte is loaded at the end of that ACK.
    assign snap_cap = scl_fall && !start_det && !stop_det && (state_q == ST_ADDR) &&
                      (bitcnt_q == 4'd8) && addr_match && sh_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (snap_cap) begin
            snap_q <= str_i;
        end
    end

    assign src_str = snap_q;
`else
    assign src_str = str_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            tx_q     <= '0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            drv_q    <= 1'b0;
            hold_q   <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
        end else if (start_det || stop_det) begin
            // Any START/STOP aborts the current byte and releases SDA at once.
            state_q  <= start_det ? ST_ADDR : ST_IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            drv_q    <= 1'b0;
            hold_q   <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // drv_q is decided on the SCL fall but only reaches the pin after the hold time.
            if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
                if (hold_q == HW'(1)) begin
                    sda_oe_q <= drv_q;
                end
            end

            if (scl_rise) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WR_DISC: begin
                        sh_q     <= {sh_q[6:0], sda_f_q};
                        bitcnt_q <= bitcnt_q + 4'd1;
                    end
                    ST_RD_DATA: bitcnt_q <= bitcnt_q + 4'd1;
                    ST_RD_ACK:  ack_q    <= sda_f_q;
                    default: ;
                endcase
            end

            if (scl_fall) begin
                hold_q <= HOLD_INIT;
                case (state_q)
                    ST_ADDR: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            if (addr_match) begin
                                state_q <= ST_ADDR_ACK;
                                drv_q   <= 1'b1;
                                busy_q  <= 1'b1;
                                rw_q    <= sh_q[0];
                            end else begin
                                state_q <= ST_IGNORE;
                                drv_q   <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        bitcnt_q <= '0;
                        if (rw_q) begin
                            state_q <= ST_RD_DATA;
                            drv_q   <= ~byte_first_d[7];
                            tx_q    <= {byte_first_d[6:0], 1'b0};
                        end else begin
                            state_q <= ST_PTR;
                            drv_q   <= 1'b0;
                        end
                    end
                    ST_PTR, ST_WR_DISC: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            state_q  <= ST_PTR_ACK;
                            drv_q    <= 1'b1;
                            if (state_q == ST_PTR) begin
                                ptr_q <= sh_q[3:0];
                            end
                        end
                    end
                    ST_PTR_ACK: begin
                        state_q <= ST_WR_DISC;
                        drv_q   <= 1'b0;
                    end
                    ST_RD_DATA: begin
                        if (bitcnt_q == 4'd8) begin
                            bitcnt_q <= '0;
                            state_q  <= ST_RD_ACK;
                            drv_q    <= 1'b0;
                        end else begin
                            drv_q <= ~tx_q[7];
                            tx_q  <= {tx_q[6:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: begin
                        // The byte just sent counts as consumed whether ACKed or not,
                        // so ptr always names the next unread byte.
                        ptr_q    <= ptr_inc_d;
                        bitcnt_q <= '0;
                        if (!ack_q) begin
                            state_q <= ST_RD_DATA;
                            drv_q   <= ~byte_next_d[7];
                            tx_q    <= {byte_next_d[6:0], 1'b0};
                        end else begin
                            state_q <= ST_IGNORE;
                            drv_q   <= 1'b0;
                        end
                    end
                    default: drv_q <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = busy_q;
    assign ptr    = ptr_q;

endmodule

// File: tb/tb_i2c_target_str_rd.sv
// Testbench for i2c_target_str_rd: an I2C initiator drives the bus, a bus monitor
// decodes every 9-bit frame and compares it against frames queued by the initiator,
// which derives them from a byte-array model of the string and pointer.
module tb_i2c_target_str_rd;
    localparam int         Q       = 10;
    localparam logic [6:0] MY_ADDR = 7'h50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scl_m;
    logic         sda_m;
    logic         sda_line;
    logic         sda_oe;
    logic         busy;
    logic [3:0]   ptr;
    logic [6:0]   i2c_addr;
    logic [0:127] str_v;

    typedef struct packed {
        logic [7:0] d;
        logic       ack;
    } frame_t;

    frame_t     exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] str_b [16];
    logic [7:0] old_b [16];
    logic [3:0] mptr;
    logic       glitch_next = 1'b0;
    logic       mon_hold    = 1'b0;
    int         oe_cnt      = 0;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull low.
    assign sda_line = sda_m & ~sda_oe;

    i2c_target_str_rd #(
        .FILT_LEN(3),
        .SDA_HOLD(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i2c_addr(i2c_addr),
        .str_i   (str_v),
        .scl_i   (scl_m),
        .sda_i   (sda_line),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .ptr     (ptr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Bus monitor: decodes frames between START and STOP and scores them.
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       mon_act  = 1'b0;
    int         nbits    = 0;
    logic [7:0] shf      = 8'h00;
    frame_t     f;

    always @(negedge clk) begin
        if (sda_oe) oe_cnt = oe_cnt + 1;
        if (!rst_n) begin
            mon_act  = 1'b0;
            nbits    = 0;
            scl_prev = scl_m;
            sda_prev = sda_line;
        end else if (!mon_hold) begin
            if (scl_m && scl_prev && sda_prev && !sda_line) begin
                mon_act = 1'b1;
                nbits   = 0;
            end else if (scl_m && scl_prev && !sda_prev && sda_line) begin
                mon_act = 1'b0;
                nbits   = 0;
            end else if (scl_m && !scl_prev && mon_act) begin
                if (nbits < 8) begin
                    shf   = {shf[6:0], sda_line};
                    nbits = nbits + 1;
                end else begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected actual=0x%0h%0h required=none", shf, sda_line);
                    end else begin
                        f = exp_q.pop_front();
                        chk("frame_data", {24'h0, shf}, {24'h0, f.d});
                        chk("frame_ack", {31'h0, sda_line}, {31'h0, f.ack});
                    end
                end
            end
            scl_prev = scl_m;
            sda_prev = sda_line;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int k = 0; k < 16; k++) str_v[k*8 +: 8] = str_b[k];
    endtask

    task automatic rand_str();
        for (int k = 0; k < 16; k++) str_b[k] = 8'($urandom);
        pack();
    endtask

    task automatic clk_bit(input logic b);
        cyc(Q);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        if (glitch_next) begin
            cyc(Q);
            mon_hold = 1'b1;
            sda_m    = ~b;
            cyc(1);
            sda_m    = b;
            cyc(1);
            mon_hold    = 1'b0;
            glitch_next = 1'b0;
            cyc(Q - 2);
        end else begin
            cyc(2 * Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic start();
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic rstart();
        cyc(Q);
        sda_m = 1'b1;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop();
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        sda_m = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack);
        exp_q.push_back('{d: d, ack: exp_ack});
        for (int i = 7; i >= 0; i--) clk_bit(d[i]);
        clk_bit(1'b1);
    endtask

    task automatic rd_byte(input logic [7:0] exp_d, input logic mack);
        exp_q.push_back('{d: exp_d, ack: mack});
        for (int i = 0; i < 8; i++) clk_bit(1'b1);
        clk_bit(mack);
    endtask

    task automatic wr_ptr(input logic [7:0] p, input int extra, input bit do_stop);
        start();
        wr_byte({MY_ADDR, 1'b0}, 1'b0);
        wr_byte(p, 1'b0);
        mptr = p[3:0];
        for (int i = 0; i < extra; i++) wr_byte(8'($urandom), 1'b0);
        if (do_stop) begin
            stop();
            chk("ptr_after_write", {28'h0, ptr}, {28'h0, mptr});
            chk("busy_after_write", {31'h0, busy}, 32'h0);
        end
    endtask

    task automatic rd_txn(input int n, input bit rep);
        if (rep) rstart();
        else start();
        wr_byte({MY_ADDR, 1'b1}, 1'b0);
        chk("busy_addressed", {31'h0, busy}, 32'h1);
        for (int k = 0; k < n; k++) begin
            rd_byte(str_b[mptr], (k == n - 1));
            mptr = mptr + 4'd1;
        end
        stop();
        chk("busy_after_stop", {31'h0, busy}, 32'h0);
        chk("sda_oe_after_stop", {31'h0, sda_oe}, 32'h0);
        chk("ptr_after_read", {28'h0, ptr}, {28'h0, mptr});
    endtask

    task automatic wrong_addr(input logic [6:0] a, input logic rw);
        int oe0;
        oe0 = oe_cnt;
        start();
        wr_byte({a, rw}, 1'b1);
        chk("busy_wrong_addr", {31'h0, busy}, 32'h0);
        stop();
        chk("sda_never_driven", 32'(oe_cnt - oe0), 32'h0);
        chk("ptr_wrong_addr", {28'h0, ptr}, {28'h0, mptr});
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       seen;
        logic [7:0] e;
        logic [6:0] a;
        int         kind;

        rst_n    = 1'b0;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        i2c_addr = MY_ADDR;
        mptr     = 4'd0;
        rand_str();
        cyc(5);
        chk("reset_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_ptr", {28'h0, ptr}, 32'h0);
        rst_n = 1'b1;
        cyc(20);

        // Pointer write then 4-byte read
        wr_ptr(8'h03, 0, 1'b1);
        rd_txn(4, 1'b0);

        // Read across the wrap
        wr_ptr(8'h0E, 0, 1'b1);
        rd_txn(4, 1'b0);

        // Foreign addresses and general call
        wrong_addr(7'h51, 1'b0);
        wrong_addr(7'h51, 1'b1);
        wrong_addr(7'h00, 1'b0);

        // Write pointer, repeated START, read one byte
        wr_ptr(8'h05, 0, 1'b0);
        rd_txn(1, 1'b1);

        // Single-cycle glitches during SCL high: low on a 1 bit, high on a 0 bit
        start();
        glitch_next = 1'b1;
        wr_byte({MY_ADDR, 1'b0}, 1'b0);
        glitch_next = 1'b1;
        wr_byte(8'h09, 1'b0);
        mptr = 4'd9;
        stop();
        chk("ptr_after_glitch", {28'h0, ptr}, 32'h9);
        rd_txn(2, 1'b0);

        // String changes after byte 0 of a 16-byte read
        wr_ptr(8'h00, 0, 1'b1);
        rand_str();
        old_b = str_b;
        start();
        wr_byte({MY_ADDR, 1'b1}, 1'b0);
        for (int k = 0; k < 16; k++) begin
`ifdef I2C_STR_SNAPSHOT_EN
            e = old_b[k];
`else
            e = (k == 0) ? old_b[k] : str_b[k];
`endif
            rd_byte(e, (k == 15));
            if (k == 0) begin
                for (int j = 0; j < 16; j++) str_b[j] = ~old_b[j];
                pack();
            end
        end
        stop();
        chk("ptr_after_16", {28'h0, ptr}, 32'h0);

        // Random transactions
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) rand_str();
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: wr_ptr(8'($urandom), int'($urandom_range(0, 2)), 1'b1);
                1: rd_txn(int'($urandom_range(1, 5)), 1'b0);
                2: begin
                    wr_ptr(8'($urandom), 0, 1'b0);
                    rd_txn(int'($urandom_range(1, 5)), 1'b1);
                end
                default: begin
                    a = 7'($urandom);
                    if (a == MY_ADDR) a = 7'h51;
                    wrong_addr(a, 1'($urandom));
                end
            endcase
        end

        // Reset during a read: SDA must be released asynchronously
        str_b[mptr] = 8'h00;
        pack();
        start();
        wr_byte({MY_ADDR, 1'b1}, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1);
            if (sda_oe) seen = 1'b1;
        end
        chk("rst_wait_drive", {31'h0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ptr", {28'h0, ptr}, 32'h0);
        cyc(3);
        rst_n = 1'b1;
        mptr  = 4'd0;
        cyc(20);
        stop();
        rd_txn(3, 1'b0);

        cyc(50);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
